// File: rtl/serial_adder_ds.sv
// serial_adder_ds
//   Digit-serial adder/subtractor. Latches two WIDTH-bit operands on a start
//   request and processes DIGIT bits per clock, LSB digit first. Each digit
//   goes through a DIGIT-wide ripple of full-adder cells, with one registered
//   carry between digits. N = WIDTH/DIGIT digit cycles per operation.
//   WIDTH must be an integer multiple of DIGIT.
//
//   Optional feature macro: SERIAL_ADD_OVF_EN adds the ovf port and the
//   signed-overflow register. Without it there is no ovf port or logic.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   start      in   request, sampled only in IDLE or DONE
//   sub        in   0 = a+b, 1 = a-b (latched with start)
//   a, b       in   WIDTH-bit operands (latched with start)
//   busy       out  high while digits are being processed
//   done       out  one-cycle pulse, sum/carry(/ovf) valid
//   sum        out  WIDTH-bit registered result
//   carry      out  registered carry-out of the MSB (1 = no borrow on sub)
//   ovf        out  registered signed overflow (SERIAL_ADD_OVF_EN only)
//   dbg_state  out  FSM state: 0 = IDLE, 1 = RUN, 2 = DONE
//
// Handshake: a request is accepted on any rising edge where start=1 and the
// FSM is in IDLE or DONE. While busy=1 start is ignored. done pulses for one
// cycle on the edge after the last digit; the results then hold until the
// next completed operation.
module serial_adder_ds #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Ripple of DIGIT full-adder cells over the low slice of the operand
  // shift registers. c[DIGIT-1] is the carry into the MSB cell of the slice,
  // which on the final digit is the carry into the operand MSB.
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] s;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cy_q;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a_q[i] ^ b_q[i] ^ c[i];
      c[i+1] = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // Result shift register fills from the top, so after N digits the first
  // (LSB) digit has arrived at bit 0.
  logic [WIDTH-1:0] slice_w;
  logic [WIDTH-1:0] res_shift;
  logic             last_digit;
  logic             accept;

  always_comb begin
    slice_w    = WIDTH'(s) << (WIDTH - DIGIT);
    res_shift  = (res_q >> DIGIT) | slice_w;
    last_digit = (cnt_q == CW'(N - 1));
    accept     = start && ((state_q == IDLE) || (state_q == DONE));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        cy_d  = c[DIGIT];
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (last_digit) begin
          state_d = DONE;
          cnt_d   = '0;
          sum_d   = res_shift;
          carry_d = c[DIGIT];
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = c[DIGIT] ^ c[DIGIT-1];
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Accepting a request is identical from IDLE and DONE. Subtraction is
    // a + ~b + 1: b is stored inverted and the +1 enters as the initial carry.
    if (accept) begin
      state_d = RUN;
      a_d     = a;
      b_d     = sub ? ~b : b;
      cy_d    = sub;
      cnt_d   = '0;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // All outputs come straight from registers.
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder_ds.sv
// tb_serial_adder_ds
//   Directed bench for serial_adder_ds. Two instances share clock and reset:
//   dut1 (WIDTH=8, DIGIT=1, N=8) and dut4 (WIDTH=8, DIGIT=4, N=2).
//   Inputs are driven and outputs sampled on the falling edge.
module tb_serial_adder_ds;

  logic       clk;
  logic       rst;

  logic       start1, sub1;
  logic [7:0] a1, b1;
  logic       busy1, done1, carry1;
  logic [7:0] sum1;
  logic [1:0] st1;

  logic       start4, sub4;
  logic [7:0] a4, b4;
  logic       busy4, done4, carry4;
  logic [7:0] sum4;
  logic [1:0] st4;

`ifdef SERIAL_ADD_OVF_EN
  logic       ovf1, ovf4;
`endif

  int checks = 0;
  int errors = 0;

  // Last completed result per instance, tracked by the bench itself.
  logic [7:0] prev1 = 8'h00;
  logic [7:0] prev4 = 8'h00;

  serial_adder_ds #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf1),
`endif
    .dbg_state(st1)
  );

  serial_adder_ds #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf4),
`endif
    .dbg_state(st4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation on dut1 (sel=1) or dut4 (sel=4), checking busy for
  // N cycles, the done cycle and the cycle after. Operand inputs are
  // scrambled while busy to show they were latched.
  task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input logic [7:0] es, input logic ec,
                        input logic eo, input string tag);
    int n;
    logic [7:0] prev;
    n    = (sel == 4) ? 2 : 8;
    prev = (sel == 4) ? prev4 : prev1;
    @(negedge clk);
    if (sel == 4) begin start4 = 1'b1; a4 = av; b4 = bv; sub4 = sv; end
    else          begin start1 = 1'b1; a1 = av; b1 = bv; sub1 = sv; end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (sel == 4) begin
          start4 = 1'b0; a4 = 8'($urandom_range(0, 255)); b4 = 8'($urandom_range(0, 255)); sub4 = ~sv;
        end else begin
          start1 = 1'b0; a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255)); sub1 = ~sv;
        end
      end
      chk({tag, "_busy"}, (sel == 4) ? busy4 : busy1, 1);
      chk({tag, "_nodone"}, (sel == 4) ? done4 : done1, 0);
      chk({tag, "_sumhold"}, (sel == 4) ? sum4 : sum1, prev);
    end
    @(negedge clk);
    chk({tag, "_busy_end"}, (sel == 4) ? busy4 : busy1, 0);
    chk({tag, "_done"}, (sel == 4) ? done4 : done1, 1);
    chk({tag, "_sum"}, (sel == 4) ? sum4 : sum1, es);
    chk({tag, "_carry"}, (sel == 4) ? carry4 : carry1, ec);
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, (sel == 4) ? ovf4 : ovf1, eo);
`endif
    @(negedge clk);
    chk({tag, "_done_off"}, (sel == 4) ? done4 : done1, 0);
    chk({tag, "_idle"}, (sel == 4) ? st4 : st1, 0);
    chk({tag, "_sum_keep"}, (sel == 4) ? sum4 : sum1, es);
    if (sel == 4) prev4 = es; else prev1 = es;
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0; sub1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
    start4 = 1'b0; sub4 = 1'b0; a4 = 8'h00; b4 = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_sum", sum1, 8'h00);
    chk("rst_carry", carry1, 0);
    chk("rst_state", st1, 0);
    chk("rst_sum4", sum4, 8'h00);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", ovf1, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy1, 0);

    // DIGIT=1 vectors
    run_op(1, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add_5a_3c");
    run_op(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run_op(1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");

    // DIGIT=4 vectors
    run_op(4, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "d4_add_7f_01");
    run_op(4, 8'h12, 8'h34, 1'b1, 8'hDE, 1'b0, 1'b0, "d4_sub_12_34");
    run_op(4, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "d4_sub_80_01");

    // Back-to-back with start held high; a changes while busy.
    @(negedge clk);
    start1 = 1'b1; a1 = 8'h01; b1 = 8'h02; sub1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 3) a1 = 8'h40;
      chk("b2b_busy1", busy1, 1);
      chk("b2b_sumhold1", sum1, prev1);
    end
    @(negedge clk);
    chk("b2b_done1", done1, 1);
    chk("b2b_sum1", sum1, 8'h03);
    chk("b2b_carry1", carry1, 0);
    @(negedge clk);
    start1 = 1'b0;
    chk("b2b_restart_busy", busy1, 1);
    chk("b2b_restart_nodone", done1, 0);
    chk("b2b_restart_sumhold", sum1, 8'h03);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("b2b_busy2", busy1, 1);
    end
    @(negedge clk);
    chk("b2b_done2", done1, 1);
    chk("b2b_sum2", sum1, 8'h42);
    @(negedge clk);
    chk("b2b_done_off", done1, 0);
    chk("b2b_idle", st1, 0);
    prev1 = 8'h42;

    // Asynchronous reset mid-RUN (shortly after edge 4).
    @(negedge clk);
    start1 = 1'b1; a1 = 8'h33; b1 = 8'h11; sub1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy1, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy1, 0);
    chk("arst_done", done1, 0);
    chk("arst_sum", sum1, 8'h00);
    chk("arst_carry", carry1, 0);
    chk("arst_state", st1, 0);
    chk("arst_sum4", sum4, 8'h00);
`ifdef SERIAL_ADD_OVF_EN
    chk("arst_ovf4", ovf4, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    prev1 = 8'h00;
    prev4 = 8'h00;
    run_op(1, 8'h33, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, "post_rst_sub");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
